// File: rtl/x3_flow_sequencer.sv
// M-cycle/T-step sequencer for X=3 flow and stack opcodes (RET/RETcc/RETI, POP, PUSH, JP, CALL, RST).
// Define X3_INT_DISPATCH_EN to add interrupt dispatch; o_Vector carries the target during LD_PC_VEC.
module x3_flow_sequencer #(
  parameter int STEPS_PER_MCYCLE = 4,
  parameter int STROBE_STEP      = 2,
  parameter int MAX_MCYCLES      = 6
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic [7:0] i_Opcode,
  input  logic [3:0] i_Conditions,
  input  logic       i_Bus_Ready,
  input  logic       i_Int_Req,
  input  logic [2:0] i_Int_Vector,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Illegal,
  output logic [3:0] o_Uop,
  output logic       o_Bus_Strobe,
  output logic [2:0] o_MCycle,
  output logic       o_EI,
  output logic       o_DI,
  output logic       o_Int_Ack,
  output logic [7:0] o_Vector
);
  localparam int SW = $clog2(STEPS_PER_MCYCLE);
  localparam int MW = $clog2(MAX_MCYCLES + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS_PER_MCYCLE - 1);
  localparam logic [SW-1:0] STROBE_AT = SW'(STROBE_STEP);

  localparam logic [3:0] UOP_IDLE     = 4'd0;
  localparam logic [3:0] UOP_INTERNAL = 4'd1;
  localparam logic [3:0] UOP_RD_PC_Z  = 4'd2;
  localparam logic [3:0] UOP_RD_PC_W  = 4'd3;
  localparam logic [3:0] UOP_RD_SP_Z  = 4'd4;
  localparam logic [3:0] UOP_RD_SP_W  = 4'd5;
  localparam logic [3:0] UOP_SP_DEC   = 4'd6;
  localparam logic [3:0] UOP_WR_HI    = 4'd7;
  localparam logic [3:0] UOP_WR_LO    = 4'd8;
  localparam logic [3:0] UOP_LD_PC_WZ = 4'd9;
  localparam logic [3:0] UOP_LD_PC_HL = 4'd10;
  localparam logic [3:0] UOP_LD_PC_VEC= 4'd11;
  localparam logic [3:0] UOP_WR_RR_HI = 4'd12;
  localparam logic [3:0] UOP_WR_RR_LO = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ILL} state_t;
  typedef enum logic [3:0] {C_RET, C_RETCC, C_POP, C_PUSH, C_JP, C_JPHL,
                            C_CALL, C_RST, C_INT, C_ILL} cls_t;

  state_t          state, state_n;
  cls_t            cls, cls_n;
  logic [SW-1:0]   step, step_n;
  logic [MW-1:0]   mc, mc_n;
  logic            taken, taken_n;
  logic [7:0]      op_q, op_n;
  logic [7:0]      vec_q, vec_n;
  logic [3:0]      uop;
  logic            mem, strobe;

  function automatic cls_t decode(input logic [7:0] op);
    cls_t c;
    c = C_ILL;
    if (op[7:6] == 2'b11) begin
      case (op[2:0])
        3'd0: if (!op[5]) c = C_RETCC;
        3'd1: if (!op[3]) c = C_POP;
              else if (!op[5]) c = C_RET;
              else if (op[5:4] == 2'b10) c = C_JPHL;
        3'd2: if (!op[5]) c = C_JP;
        3'd3: if (op[5:3] == 3'b000) c = C_JP;
        3'd4: if (!op[5]) c = C_CALL;
        3'd5: if (!op[3]) c = C_PUSH;
              else if (op[5:4] == 2'b00) c = C_CALL;
        3'd7: c = C_RST;
        default: c = C_ILL;
      endcase
    end
    return c;
  endfunction

  function automatic logic [3:0] uop_of(input cls_t c, input int m, input logic tk);
    logic [3:0] u;
    u = UOP_INTERNAL;
    case (c)
      C_RET:   case (m) 0: u = UOP_RD_SP_Z; 1: u = UOP_RD_SP_W; 2: u = UOP_LD_PC_WZ; default: ; endcase
      C_RETCC: if (tk) case (m) 1: u = UOP_RD_SP_Z; 2: u = UOP_RD_SP_W; 3: u = UOP_LD_PC_WZ; default: ; endcase
      C_POP:   case (m) 0: u = UOP_RD_SP_Z; 1: u = UOP_RD_SP_W; default: ; endcase
      C_PUSH:  case (m) 0: u = UOP_SP_DEC; 1: u = UOP_WR_RR_HI; 2: u = UOP_WR_RR_LO; default: ; endcase
      C_JP:    case (m) 0: u = UOP_RD_PC_Z; 1: u = UOP_RD_PC_W; 2: if (tk) u = UOP_LD_PC_WZ; default: ; endcase
      C_JPHL:  u = UOP_LD_PC_HL;
      C_CALL:  case (m)
                 0: u = UOP_RD_PC_Z;
                 1: u = UOP_RD_PC_W;
                 2: if (tk) u = UOP_SP_DEC;
                 3: u = UOP_WR_HI;
                 4: u = UOP_WR_LO;
                 5: u = UOP_LD_PC_WZ;
                 default: ;
               endcase
      C_RST:   case (m) 0: u = UOP_SP_DEC; 1: u = UOP_WR_HI; 2: u = UOP_WR_LO; default: u = UOP_LD_PC_VEC; endcase
      C_INT:   case (m) 0: u = UOP_INTERNAL; 1: u = UOP_SP_DEC; 2: u = UOP_WR_HI; 3: u = UOP_WR_LO;
                 default: u = UOP_LD_PC_VEC; endcase
      default: u = UOP_IDLE;
    endcase
    return u;
  endfunction

  function automatic int last_mc(input cls_t c, input logic tk);
    case (c)
      C_RET:   return 3;
      C_RETCC: return tk ? 4 : 1;
      C_POP:   return 2;
      C_PUSH:  return 3;
      C_JP:    return tk ? 3 : 2;
      C_CALL:  return tk ? 5 : 2;
      C_RST:   return 3;
      C_INT:   return 4;
      default: return 0;
    endcase
  endfunction

  // M-cycle whose final step samples i_Conditions; -1 means never
  function automatic int cond_mc(input cls_t c);
    case (c)
      C_RETCC: return 0;
      C_JP, C_CALL: return 1;
      default: return -1;
    endcase
  endfunction

  function automatic logic is_mem(input logic [3:0] u);
    return (u inside {UOP_RD_PC_Z, UOP_RD_PC_W, UOP_RD_SP_Z, UOP_RD_SP_W,
                      UOP_WR_HI, UOP_WR_LO, UOP_WR_RR_HI, UOP_WR_RR_LO});
  endfunction

  always_comb begin
    state_n = state;
    cls_n   = cls;
    step_n  = step;
    mc_n    = mc;
    taken_n = taken;
    op_n    = op_q;
    vec_n   = vec_q;
    uop     = UOP_IDLE;
    mem     = 1'b0;
    strobe  = 1'b0;
    case (state)
      S_IDLE: begin
        step_n = '0;
        mc_n   = '0;
`ifdef X3_INT_DISPATCH_EN
        if (i_Int_Req) begin
          state_n = S_RUN;
          cls_n   = C_INT;
          vec_n   = {2'b01, i_Int_Vector, 3'b000};
        end else
`endif
        if (i_Start) begin
          op_n    = i_Opcode;
          cls_n   = decode(i_Opcode);
          vec_n   = {2'b00, i_Opcode[5:3], 3'b000};
          state_n = (decode(i_Opcode) == C_ILL) ? S_ILL : S_RUN;
        end
      end
      S_RUN: begin
        uop    = uop_of(cls, int'(mc), taken);
        mem    = is_mem(uop);
        strobe = mem && (step == STROBE_AT);
        if (strobe && !i_Bus_Ready) begin
          step_n = step;
        end else if (step != LAST_STEP) begin
          step_n = step + 1'b1;
        end else begin
          step_n = '0;
          // Unconditional forms (odd opcodes) are always taken
          if (int'(mc) == cond_mc(cls))
            taken_n = op_q[0] ? 1'b1 : i_Conditions[op_q[4:3]];
          if (int'(mc) == last_mc(cls, taken_n)) begin
            state_n = S_DONE;
            mc_n    = '0;
          end else begin
            mc_n = mc + 1'b1;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state <= S_IDLE;
      cls   <= C_ILL;
      step  <= '0;
      mc    <= '0;
      taken <= 1'b0;
    end else begin
      state <= state_n;
      cls   <= cls_n;
      step  <= step_n;
      mc    <= mc_n;
      taken <= taken_n;
    end
  end

  always_ff @(posedge i_Clk) begin
    op_q  <= op_n;
    vec_q <= vec_n;
  end

`ifdef X3_INT_DISPATCH_EN
  logic ack;
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) ack <= 1'b0;
    else         ack <= (state == S_IDLE) && i_Int_Req;
  end
  assign o_Int_Ack = ack;
  assign o_DI      = (state == S_DONE) && (cls == C_INT);
`else
  logic unused_int;
  assign unused_int = ^{i_Int_Req, i_Int_Vector};
  assign o_Int_Ack  = 1'b0;
  assign o_DI       = 1'b0;
`endif

  assign o_Busy       = (state == S_RUN) || (state == S_DONE);
  assign o_Done       = (state == S_DONE);
  assign o_Illegal    = (state == S_ILL);
  assign o_Uop        = uop;
  assign o_Bus_Strobe = strobe;
  assign o_MCycle     = 3'(mc);
  assign o_EI         = (state == S_DONE) && (cls == C_RET) && (op_q == 8'hD9);
  assign o_Vector     = (uop == UOP_LD_PC_VEC) ? vec_q : 8'h00;
endmodule

// File: tb/tb_x3_flow_sequencer.sv
// Scoreboard bench for x3_flow_sequencer: stimulus queues expected instruction summaries,
// a monitor rebuilds each summary from the outputs and compares at o_Done / o_Illegal.
module tb_x3_flow_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] opcode;
  logic [3:0] cond;
  logic       ready;
  logic       int_req;
  logic [2:0] int_vec;
  logic       busy, done, illegal, strobe, ei, di, int_ack;
  logic [3:0] uop;
  logic [2:0] mcycle;
  logic [7:0] vector;

  x3_flow_sequencer dut (
    .i_Clk(clk), .i_Reset(rst), .i_Start(start), .i_Opcode(opcode),
    .i_Conditions(cond), .i_Bus_Ready(ready), .i_Int_Req(int_req), .i_Int_Vector(int_vec),
    .o_Busy(busy), .o_Done(done), .o_Illegal(illegal), .o_Uop(uop),
    .o_Bus_Strobe(strobe), .o_MCycle(mcycle), .o_EI(ei), .o_DI(di),
    .o_Int_Ack(int_ack), .o_Vector(vector)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [23:0] uops;
    int          nmc;
    int          clks;
    int          strobes;
    bit          ei;
    bit          di;
    bit          ill;
    bit          ack;
    logic [7:0]  vec;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(input logic [23:0] u, input int n, input int ck, input int st,
                              input bit e, input bit d, input bit il, input bit ak, input logic [7:0] v);
    exp_t x;
    x.nm = ""; x.uops = u; x.nmc = n; x.clks = ck; x.strobes = st;
    x.ei = e; x.di = d; x.ill = il; x.ack = ak; x.vec = v;
    return x;
  endfunction

  // Monitor: accumulate per-instruction observations, pop and compare on completion
  initial begin
    logic [23:0] a_uops;
    int a_nmc, a_clks, a_str;
    bit a_ack, in_instr;
    logic [7:0] a_vec;
    logic [2:0] prev_mc;
    exp_t e;
    a_uops = '0; a_nmc = 0; a_clks = 0; a_str = 0; a_ack = 0; in_instr = 0; a_vec = '0; prev_mc = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        a_uops = '0; a_nmc = 0; a_clks = 0; a_str = 0; a_ack = 0; in_instr = 0; a_vec = '0;
      end else begin
        if (busy && !done) begin
          if ((!in_instr || mcycle != prev_mc) && a_nmc < 6) begin
            a_uops[4*a_nmc +: 4] = uop;
            a_nmc++;
          end
          in_instr = 1;
          prev_mc  = mcycle;
          a_clks++;
          if (strobe) a_str++;
          if (uop == 4'd11) a_vec = vector;
        end
        if (int_ack) a_ack = 1;
        if (done || illegal) begin
          if (sb.size() == 0) begin
            chk("unexpected_completion", 1, 0);
          end else begin
            e = sb.pop_front();
            chk({e.nm, "_uops"}, int'(a_uops), int'(e.uops));
            chk({e.nm, "_mcycles"}, a_nmc, e.nmc);
            chk({e.nm, "_clks"}, a_clks, e.clks);
            chk({e.nm, "_strobes"}, a_str, e.strobes);
            chk({e.nm, "_ei"}, int'(ei), int'(e.ei));
            chk({e.nm, "_di"}, int'(di), int'(e.di));
            chk({e.nm, "_illegal"}, int'(illegal), int'(e.ill));
            chk({e.nm, "_ack"}, int'(a_ack), int'(e.ack));
            chk({e.nm, "_vector"}, int'(a_vec), int'(e.vec));
            if (illegal) chk({e.nm, "_busy_during_illegal"}, int'(busy), 0);
          end
          a_uops = '0; a_nmc = 0; a_clks = 0; a_str = 0; a_ack = 0; in_instr = 0; a_vec = '0;
        end
      end
    end
  end

  task automatic run_instr(input string nm, input logic [7:0] op, input logic [3:0] c,
                           input logic [3:0] cl, input bit stall, input bit poke,
                           input bit ireq, input logic [2:0] iv, input exp_t e);
    int k;
    bit did;
    e.nm = nm;
    sb.push_back(e);
    @(negedge clk);
    start = 1; opcode = op; cond = c; int_req = ireq; int_vec = iv;
    @(negedge clk);
    start = 0; int_req = 0;
    k = 0; did = 0;
    while (sb.size() != 0 && k < 200) begin
      if (poke && k == 3) begin start = 1; opcode = 8'hD3; end
      if (poke && k == 4) start = 0;
      if (k == 11) cond = cl;
      if (stall && !did && strobe && uop == 4'd12) begin
        ready = 0;
        repeat (3) @(negedge clk);
        ready = 1;
        did = 1;
        k += 3;
      end
      @(negedge clk);
      k++;
    end
    start = 0;
    chk({nm, "_pending"}, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    rst = 1; start = 0; opcode = 8'h00; cond = 4'h0; ready = 1; int_req = 0; int_vec = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);    chk("rst_illegal", illegal, 0);
    chk("rst_uop", uop, 0);     chk("rst_strobe", strobe, 0); chk("rst_mcycle", mcycle, 0);
    chk("rst_ei", ei, 0);       chk("rst_di", di, 0);         chk("rst_ack", int_ack, 0);
    rst = 0;

    // name, op, cond, late cond, stall, poke, int_req, int_vec, expected
    run_instr("ret",        8'hC9, 4'h0, 4'hF, 0, 1, 0, 3'd0, mk(24'h001954, 4, 16, 2, 0, 0, 0, 0, 8'h00));
    run_instr("call_nz_t",  8'hC4, 4'h1, 4'h1, 0, 0, 0, 3'd0, mk(24'h987632, 6, 24, 4, 0, 0, 0, 0, 8'h00));
    run_instr("call_nz_nt", 8'hC4, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h000132, 3, 12, 2, 0, 0, 0, 0, 8'h00));
    run_instr("push_stall", 8'hF5, 4'h0, 4'h0, 1, 0, 0, 3'd0, mk(24'h001DC6, 4, 19, 5, 0, 0, 0, 0, 8'h00));
    run_instr("rst38",      8'hFF, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h00B876, 4, 16, 2, 0, 0, 0, 0, 8'h38));
    run_instr("ill_d3",     8'hD3, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h000000, 0, 0, 0, 0, 0, 1, 0, 8'h00));
    @(negedge clk);
    chk("busy_after_illegal", busy, 0);
    run_instr("reti",       8'hD9, 4'h0, 4'h0, 0, 1, 0, 3'd0, mk(24'h001954, 4, 16, 2, 1, 0, 0, 0, 8'h00));
    run_instr("ret_nz_t",   8'hC0, 4'h1, 4'h0, 0, 0, 0, 3'd0, mk(24'h019541, 5, 20, 2, 0, 0, 0, 0, 8'h00));
    run_instr("ret_z_nt",   8'hC8, 4'h1, 4'h1, 0, 0, 0, 3'd0, mk(24'h000011, 2, 8, 0, 0, 0, 0, 0, 8'h00));
    run_instr("jp",         8'hC3, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h001932, 4, 16, 2, 0, 0, 0, 0, 8'h00));
    run_instr("jp_c_t",     8'hDA, 4'h8, 4'h0, 0, 0, 0, 3'd0, mk(24'h001932, 4, 16, 2, 0, 0, 0, 0, 8'h00));
    run_instr("jp_nc_nt",   8'hD2, 4'h8, 4'h8, 0, 0, 0, 3'd0, mk(24'h000132, 3, 12, 2, 0, 0, 0, 0, 8'h00));
    run_instr("jp_hl",      8'hE9, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h00000A, 1, 4, 0, 0, 0, 0, 0, 8'h00));
    run_instr("pop_hl",     8'hE1, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h000154, 3, 12, 2, 0, 0, 0, 0, 8'h00));
    run_instr("call",       8'hCD, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h987632, 6, 24, 4, 0, 0, 0, 0, 8'h00));
    run_instr("call_z_late",8'hCC, 4'h2, 4'h0, 0, 0, 0, 3'd0, mk(24'h987632, 6, 24, 4, 0, 0, 0, 0, 8'h00));
    run_instr("rst28",      8'hEF, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h00B876, 4, 16, 2, 0, 0, 0, 0, 8'h28));
    run_instr("ill_fe",     8'hFE, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h000000, 0, 0, 0, 0, 0, 1, 0, 8'h00));
`ifdef X3_INT_DISPATCH_EN
    run_instr("int_disp",   8'hC9, 4'h0, 4'h0, 0, 0, 1, 3'd2, mk(24'h0B8761, 5, 20, 2, 0, 1, 0, 1, 8'h50));
`else
    run_instr("int_ignored",8'hC9, 4'h0, 4'h0, 0, 0, 1, 3'd2, mk(24'h001954, 4, 16, 2, 0, 0, 0, 0, 8'h00));
`endif

    // Asynchronous reset in CALL M4 step 1 aborts immediately
    @(negedge clk);
    start = 1; opcode = 8'hCD; cond = 4'h0;
    @(negedge clk);
    start = 0;
    repeat (17) @(negedge clk);
    chk("abort_pre_mcycle", mcycle, 4);
    chk("abort_pre_uop", uop, 8);
    #2 rst = 1;
    #1;
    chk("abort_busy", busy, 0);     chk("abort_uop", uop, 0);
    chk("abort_strobe", strobe, 0); chk("abort_mcycle", mcycle, 0);
    @(posedge clk);
    #1;
    chk("abort_busy_edge", busy, 0); chk("abort_done_edge", done, 0);
    @(negedge clk);
    rst = 0;
    run_instr("jp_hl_after_rst", 8'hE9, 4'h0, 4'h0, 0, 0, 0, 3'd0, mk(24'h00000A, 1, 4, 0, 0, 0, 0, 0, 8'h00));

    repeat (3) @(negedge clk);
    chk("idle_at_end", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
